riscv_wb: RTL and testbench
===========================

// Module: riscv_wb
// PURPOSE
//  Writeback stage; sits directly downstream of the memory stage.
//  - Accepts one result per handshake; waits for the data bus read response on loads.
//  - Extracts and sign/zero-extends the addressed byte/half/word.
//  - Issues a single registered write to the register file; never writes x0.
// PARAMETERS
//  XLEN  32  datapath width (only 32 supported)
// PORTS
//  clk             in   1           clock, rising edge
//  rstn            in   1           reset, asynchronous, active-low
//  mem_wb_rdy      in   1           upstream result valid
//  mem_wb_ack      out  1           result accepted this cycle (when rdy high)
//  mem_wb_funct    in   LD_FUNCT_W  load op; LD_NOP = non-load result
//  mem_wb_baddr    in   2           byte offset of load address
//  mem_wb_data     in   32          non-load result value
//  mem_wb_rsd      in   5           destination register
//  data_bif_rvalid in   1           read response valid (1-cycle pulse)
//  data_bif_rdata  in   32          read response word
//  wb_rf_wen       out  1           register file write enable
//  wb_rf_waddr     out  5           register file write address
//  wb_rf_wdata     out  32          register file write data
// BEHAVIOUR
//  Reset: state=IDLE, wb_rf_wen=0, wb_rf_waddr=0, wb_rf_wdata=0, pending load dropped.
//  Handshake: transfer when mem_wb_rdy && mem_wb_ack.
//    mem_wb_ack = (state==IDLE), combinational.
//  FSM:
//    IDLE, transfer, funct==LD_NOP:
//      next-cycle wen=(rsd!=0), waddr=rsd, wdata=mem_wb_data. Stay IDLE.
//    IDLE, transfer, load, rvalid=1 same cycle:
//      complete immediately; write extracted data next cycle. Stay IDLE.
//    IDLE, transfer, load, rvalid=0:
//      latch funct/baddr/rsd; go WAIT.
//    WAIT: ack=0; hold until rvalid.
//      On rvalid: next-cycle wen=(rsd_q!=0) with extracted data; go IDLE.
//    rvalid in IDLE without accepted load: ignored (simulation assertion fires).
//  wb_rf_wen is a 1-cycle pulse; waddr/wdata hold their last value when wen=0.
//  Latency:
//    non-load: wen 1 cycle after transfer.
//    load: wen 1 cycle after rvalid.
//    Throughput: 1/cycle for non-loads and same-cycle-response loads.
//  Extraction (rdata=r, baddr=b):
//    LB/LBU: r[8*b+:8], sign-/zero-extended.
//    LH/LHU: b[1] ? r[31:16] : r[15:0], sign-/zero-extended; b[0] ignored (misaligned = undefined).
//    LW: r; b ignored.
//    Unknown funct: treated as LW.
//  Reset asserted in WAIT: load abandoned, no write; a later rvalid is ignored.
// CONFIGURATION
//  RISCV_WB_FWD_EN defined: extra outputs wb_fwd_valid(1), wb_fwd_rsd(5), wb_fwd_data(32).
//    Combinational: the value that will be written next cycle, for decode bypass.
//    wb_fwd_valid=0 when rsd==0 or no completion this cycle.
//  RISCV_WB_FWD_EN undefined: ports and logic absent; only the registered rf write path exists.
// STRUCTURE
//  riscv_functions.vh: LD_FUNCT_W, LD_NOP/LB/LH/LW/LBU/LHU encodings, FSM state encodings.
//  Sub-module riscv_wb_ldext: combinational extractor (funct, baddr, rdata -> 32b value).
//  Top holds the FSM, pending-load registers and the rf write registers.
// TESTING
//  1. Non-load: rdy=1, LD_NOP, rsd=5, data=0xDEADBEEF
//     -> next cycle wen=1, waddr=5, wdata=0xDEADBEEF.
//  2. LB, baddr=3, rvalid same cycle, rdata=0x80FF_0000 -> wdata=0xFFFFFF80.
//     LBU, same inputs -> wdata=0x00000080.
//  3. LH, baddr=2, rvalid 3 cycles late, rdata=0x8001_1234
//     -> ack=0 for 3 cycles; wdata=0xFFFF8001 one cycle after rvalid.
//  4. LW, rsd=0, rdata=0x12345678 -> wen stays 0; ack returns high after rvalid.
//  5. rstn low while in WAIT, then rvalid pulse -> no wen; ack=1 after reset.
//  6. Back-to-back: 4 non-load ops, rsd=1..4
//     -> 4 consecutive wen pulses, waddr 1,2,3,4; fwd outputs match when RISCV_WB_FWD_EN defined.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// Shared encodings for the writeback stage: load function codes, FSM states
// and the byte/half extension helper used by the load extractor.
package riscv_wb_pkg;

    localparam int LD_FUNCT_W = 3;

    localparam logic [LD_FUNCT_W-1:0] LD_NOP = 3'd0;
    localparam logic [LD_FUNCT_W-1:0] LD_LB  = 3'd1;
    localparam logic [LD_FUNCT_W-1:0] LD_LH  = 3'd2;
    localparam logic [LD_FUNCT_W-1:0] LD_LW  = 3'd3;
    localparam logic [LD_FUNCT_W-1:0] LD_LBU = 3'd4;
    localparam logic [LD_FUNCT_W-1:0] LD_LHU = 3'd5;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_e;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        ext8 = {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        ext16 = {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/riscv_wb_chk.sv
// Checker: a read response must only arrive while a load is outstanding or is
// being accepted in the same cycle.
module riscv_wb_chk
    import riscv_wb_pkg::*;
(
    input logic clk,
    input logic rstn,
    input logic in_wait,
    input logic load_xfer,
    input logic rvalid
);

    a_no_stray_rvalid: assert property (
        @(posedge clk) disable iff (!rstn)
        rvalid |-> (in_wait || load_xfer)
    );

endmodule

// File: rtl/riscv_wb_ldext.sv
// Combinational load-data extractor: picks the addressed byte/half/word out
// of the read response and sign- or zero-extends it.
module riscv_wb_ldext
    import riscv_wb_pkg::*;
(
    input  logic [LD_FUNCT_W-1:0] funct,
    input  logic [1:0]            baddr,
    input  logic [31:0]           rdata,
    output logic [31:0]           ext_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata[{baddr, 3'b000} +: 8];
    // Halfword offset bit 0 is ignored; misaligned halves are undefined anyway.
    assign half_s = baddr[1] ? rdata[31:16] : rdata[15:0];

    // Select and extend the loaded value; anything unrecognised is a full word.
    always_comb begin
        ext_data = rdata;
        case (funct)
            LD_LB:   ext_data = ext8(byte_s, 1'b1);
            LD_LBU:  ext_data = ext8(byte_s, 1'b0);
            LD_LH:   ext_data = ext16(half_s, 1'b1);
            LD_LHU:  ext_data = ext16(half_s, 1'b0);
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_wb.sv
// Writeback stage: accepts memory-stage results, waits for load data and
// issues one registered register-file write. Optional decode bypass outputs
// are enabled with RISCV_WB_FWD_EN.
module riscv_wb
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mem_wb_rdy,
    output logic                  mem_wb_ack,
    input  logic [LD_FUNCT_W-1:0] mem_wb_funct,
    input  logic [1:0]            mem_wb_baddr,
    input  logic [XLEN-1:0]       mem_wb_data,
    input  logic [4:0]            mem_wb_rsd,
    input  logic                  data_bif_rvalid,
    input  logic [XLEN-1:0]       data_bif_rdata,
    output logic                  wb_rf_wen,
    output logic [4:0]            wb_rf_waddr,
    output logic [XLEN-1:0]       wb_rf_wdata
`ifdef RISCV_WB_FWD_EN
    ,
    output logic                  wb_fwd_valid,
    output logic [4:0]            wb_fwd_rsd,
    output logic [XLEN-1:0]       wb_fwd_data
`endif
);

    wb_state_e             state_q, state_d;
    logic [LD_FUNCT_W-1:0] funct_q, funct_d;
    logic [1:0]            baddr_q, baddr_d;
    logic [4:0]            rsd_q, rsd_d;
    logic                  wen_q, wen_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;

    logic                  xfer_s;
    logic                  is_load_s;
    logic                  done_s;
    logic [4:0]            done_rsd_s;
    logic [XLEN-1:0]       done_data_s;
    logic [LD_FUNCT_W-1:0] ext_funct_s;
    logic [1:0]            ext_baddr_s;
    logic [XLEN-1:0]       ext_data_s;

    assign mem_wb_ack = (state_q == WB_IDLE);
    assign xfer_s     = mem_wb_rdy && mem_wb_ack;
    assign is_load_s  = (mem_wb_funct != LD_NOP);

    // In WAIT the extractor must see the latched load, not the live inputs.
    assign ext_funct_s = (state_q == WB_WAIT) ? funct_q : mem_wb_funct;
    assign ext_baddr_s = (state_q == WB_WAIT) ? baddr_q : mem_wb_baddr;

    riscv_wb_ldext u_ldext (
        .funct    (ext_funct_s),
        .baddr    (ext_baddr_s),
        .rdata    (data_bif_rdata),
        .ext_data (ext_data_s)
    );

    // Next-state, pending-load capture and completion selection.
    always_comb begin
        state_d     = state_q;
        funct_d     = funct_q;
        baddr_d     = baddr_q;
        rsd_d       = rsd_q;
        done_s      = 1'b0;
        done_rsd_s  = mem_wb_rsd;
        done_data_s = mem_wb_data;
        case (state_q)
            WB_IDLE: begin
                if (xfer_s && !is_load_s) begin
                    done_s = 1'b1;
                end else if (xfer_s && data_bif_rvalid) begin
                    done_s      = 1'b1;
                    done_data_s = ext_data_s;
                end else if (xfer_s) begin
                    funct_d = mem_wb_funct;
                    baddr_d = mem_wb_baddr;
                    rsd_d   = mem_wb_rsd;
                    state_d = WB_WAIT;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            WB_WAIT: begin
                done_rsd_s  = rsd_q;
                done_data_s = ext_data_s;
                if (data_bif_rvalid) begin
                    done_s  = 1'b1;
                    state_d = WB_IDLE;
                end else begin
                    state_d = WB_WAIT;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Register-file write: a one-cycle pulse; address/data hold otherwise.
    always_comb begin
        wen_d = done_s && (done_rsd_s != 5'd0);
        if (wen_d) begin
            waddr_d = done_rsd_s;
            wdata_d = done_data_s;
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // State, pending-load and write-port registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= WB_IDLE;
            funct_q <= LD_NOP;
            baddr_q <= 2'd0;
            rsd_q   <= 5'd0;
            wen_q   <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            baddr_q <= baddr_d;
            rsd_q   <= rsd_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wb_rf_wen   = wen_q;
    assign wb_rf_waddr = waddr_q;
    assign wb_rf_wdata = wdata_q;

`ifdef RISCV_WB_FWD_EN
    assign wb_fwd_valid = wen_d;
    assign wb_fwd_rsd   = done_rsd_s;
    assign wb_fwd_data  = done_data_s;
`endif

    riscv_wb_chk u_chk (
        .clk       (clk),
        .rstn      (rstn),
        .in_wait   (state_q == WB_WAIT),
        .load_xfer (xfer_s && is_load_s),
        .rvalid    (data_bif_rvalid)
    );

endmodule

// File: tb/tb_riscv_wb.sv
// Directed self-checking bench for riscv_wb: vector table for single-cycle
// completions plus hand sequences for waits, x0, reset-in-WAIT and streaming.
module tb_riscv_wb;
    import riscv_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_wb_rdy;
    logic        mem_wb_ack;
    logic [2:0]  mem_wb_funct;
    logic [1:0]  mem_wb_baddr;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rsd;
    logic        data_bif_rvalid;
    logic [31:0] data_bif_rdata;
    logic        wb_rf_wen;
    logic [4:0]  wb_rf_waddr;
    logic [31:0] wb_rf_wdata;
`ifdef RISCV_WB_FWD_EN
    logic        wb_fwd_valid;
    logic [4:0]  wb_fwd_rsd;
    logic [31:0] wb_fwd_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    riscv_wb #(.XLEN(32)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .mem_wb_rdy      (mem_wb_rdy),
        .mem_wb_ack      (mem_wb_ack),
        .mem_wb_funct    (mem_wb_funct),
        .mem_wb_baddr    (mem_wb_baddr),
        .mem_wb_data     (mem_wb_data),
        .mem_wb_rsd      (mem_wb_rsd),
        .data_bif_rvalid (data_bif_rvalid),
        .data_bif_rdata  (data_bif_rdata),
        .wb_rf_wen       (wb_rf_wen),
        .wb_rf_waddr     (wb_rf_waddr),
        .wb_rf_wdata     (wb_rf_wdata)
`ifdef RISCV_WB_FWD_EN
        ,
        .wb_fwd_valid    (wb_fwd_valid),
        .wb_fwd_rsd      (wb_fwd_rsd),
        .wb_fwd_data     (wb_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  funct;
        logic [1:0]  baddr;
        logic [31:0] data;
        logic [4:0]  rsd;
        logic [31:0] rdata;
        logic        exp_wen;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_wb_rdy      = 1'b0;
        mem_wb_funct    = LD_NOP;
        mem_wb_baddr    = 2'd0;
        mem_wb_data     = 32'd0;
        mem_wb_rsd      = 5'd0;
        data_bif_rvalid = 1'b0;
        data_bif_rdata  = 32'd0;
    endtask

    task automatic drive(input logic [2:0] f, input logic [1:0] b, input logic [31:0] d,
                         input logic [4:0] r, input logic rv, input logic [31:0] rd);
        mem_wb_rdy      = 1'b1;
        mem_wb_funct    = f;
        mem_wb_baddr    = b;
        mem_wb_data     = d;
        mem_wb_rsd      = r;
        data_bif_rvalid = rv;
        data_bif_rdata  = rd;
    endtask

    initial begin
        vecs[0]  = '{LD_NOP, 2'd0, 32'hDEADBEEF, 5'd5,  32'h0,         1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{LD_LB,  2'd3, 32'h0,        5'd6,  32'h80FF_0000, 1'b1, 5'd6,  32'hFFFFFF80};
        vecs[2]  = '{LD_LBU, 2'd3, 32'h0,        5'd7,  32'h80FF_0000, 1'b1, 5'd7,  32'h00000080};
        vecs[3]  = '{LD_LB,  2'd1, 32'h0,        5'd8,  32'h0000_7F00, 1'b1, 5'd8,  32'h0000007F};
        vecs[4]  = '{LD_LH,  2'd0, 32'h0,        5'd9,  32'h0000_8001, 1'b1, 5'd9,  32'hFFFF8001};
        vecs[5]  = '{LD_LHU, 2'd2, 32'h0,        5'd10, 32'h8001_1234, 1'b1, 5'd10, 32'h00008001};
        vecs[6]  = '{LD_LH,  2'd1, 32'h0,        5'd11, 32'h1234_7FFE, 1'b1, 5'd11, 32'h00007FFE};
        vecs[7]  = '{LD_LW,  2'd2, 32'h0,        5'd12, 32'hCAFE_F00D, 1'b1, 5'd12, 32'hCAFEF00D};
        vecs[8]  = '{3'd7,   2'd1, 32'h0,        5'd13, 32'h1357_9BDF, 1'b1, 5'd13, 32'h13579BDF};
        vecs[9]  = '{LD_LBU, 2'd0, 32'h0,        5'd14, 32'h0000_00FF, 1'b1, 5'd14, 32'h000000FF};
        vecs[10] = '{LD_NOP, 2'd0, 32'h0000_1111, 5'd0, 32'h0,         1'b0, 5'd14, 32'h000000FF};

        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("reset_wen",   {31'd0, wb_rf_wen},   32'd0);
        chk("reset_waddr", {27'd0, wb_rf_waddr}, 32'd0);
        chk("reset_wdata", wb_rf_wdata,          32'd0);
        chk("reset_ack",   {31'd0, mem_wb_ack},  32'd1);
        rstn = 1'b1;
        @(negedge clk);

        // Single-cycle completions: non-loads and same-cycle-response loads.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].funct, vecs[i].baddr, vecs[i].data, vecs[i].rsd,
                  vecs[i].funct != LD_NOP, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d_ack", i), {31'd0, mem_wb_ack}, 32'd1);
`ifdef RISCV_WB_FWD_EN
            chk($sformatf("v%0d_fwd_valid", i), {31'd0, wb_fwd_valid}, {31'd0, vecs[i].exp_wen});
            if (vecs[i].exp_wen) begin
                chk($sformatf("v%0d_fwd_data", i), wb_fwd_data, vecs[i].exp_wdata);
            end
`endif
            @(negedge clk);
            idle_inputs();
            chk($sformatf("v%0d_wen", i),   {31'd0, wb_rf_wen},   {31'd0, vecs[i].exp_wen});
            chk($sformatf("v%0d_waddr", i), {27'd0, wb_rf_waddr}, {27'd0, vecs[i].exp_waddr});
            chk($sformatf("v%0d_wdata", i), wb_rf_wdata,          vecs[i].exp_wdata);
        end

        // LH at offset 2, response three cycles after acceptance.
        drive(LD_LH, 2'd2, 32'h0, 5'd15, 1'b0, 32'h0);
        @(negedge clk);
        idle_inputs();
        mem_wb_rsd   = 5'd20;
        mem_wb_baddr = 2'd0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lh_wait_ack%0d", c), {31'd0, mem_wb_ack}, 32'd0);
            chk($sformatf("lh_wait_wen%0d", c), {31'd0, wb_rf_wen}, 32'd0);
            if (c < 2) @(negedge clk);
        end
        data_bif_rvalid = 1'b1;
        data_bif_rdata  = 32'h8001_1234;
`ifdef RISCV_WB_FWD_EN
        #1;
        chk("lh_fwd_valid", {31'd0, wb_fwd_valid}, 32'd1);
        chk("lh_fwd_rsd",   {27'd0, wb_fwd_rsd},   32'd15);
        chk("lh_fwd_data",  wb_fwd_data,           32'hFFFF8001);
`endif
        @(negedge clk);
        idle_inputs();
        chk("lh_wen",   {31'd0, wb_rf_wen},   32'd1);
        chk("lh_waddr", {27'd0, wb_rf_waddr}, 32'd15);
        chk("lh_wdata", wb_rf_wdata,          32'hFFFF8001);
        chk("lh_ack",   {31'd0, mem_wb_ack},  32'd1);
        @(negedge clk);
        chk("lh_pulse_end", {31'd0, wb_rf_wen},   32'd0);
        chk("lh_hold_addr", {27'd0, wb_rf_waddr}, 32'd15);

        // LW to x0 after a wait: no write, handshake recovers.
        drive(LD_LW, 2'd0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        idle_inputs();
        chk("x0_wait_ack", {31'd0, mem_wb_ack}, 32'd0);
        @(negedge clk);
        data_bif_rvalid = 1'b1;
        data_bif_rdata  = 32'h1234_5678;
`ifdef RISCV_WB_FWD_EN
        #1;
        chk("x0_fwd_valid", {31'd0, wb_fwd_valid}, 32'd0);
`endif
        @(negedge clk);
        idle_inputs();
        chk("x0_wen",   {31'd0, wb_rf_wen},  32'd0);
        chk("x0_ack",   {31'd0, mem_wb_ack}, 32'd1);
        chk("x0_wdata", wb_rf_wdata,         32'hFFFF8001);

        // Reset while waiting: load dropped, response during reset ignored.
        drive(LD_LW, 2'd0, 32'h0, 5'd3, 1'b0, 32'h0);
        @(negedge clk);
        idle_inputs();
        chk("rst_wait_ack", {31'd0, mem_wb_ack}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("rst_ack",   {31'd0, mem_wb_ack},  32'd1);
        chk("rst_waddr", {27'd0, wb_rf_waddr}, 32'd0);
        @(negedge clk);
        data_bif_rvalid = 1'b1;
        data_bif_rdata  = 32'hAAAA_AAAA;
        @(negedge clk);
        data_bif_rvalid = 1'b0;
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst_post_wen%0d", c), {31'd0, wb_rf_wen}, 32'd0);
            chk($sformatf("rst_post_ack%0d", c), {31'd0, mem_wb_ack}, 32'd1);
        end
        chk("rst_post_wdata", wb_rf_wdata, 32'd0);

        // Back-to-back non-loads to x1..x4.
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) begin
                chk($sformatf("b2b_wen%0d", i - 1),   {31'd0, wb_rf_wen},   32'd1);
                chk($sformatf("b2b_waddr%0d", i - 1), {27'd0, wb_rf_waddr}, i - 1);
                chk($sformatf("b2b_wdata%0d", i - 1), wb_rf_wdata,          32'h100 + i - 1);
            end
            if (i <= 4) begin
                drive(LD_NOP, 2'd0, 32'h100 + i, i[4:0], 1'b0, 32'h0);
`ifdef RISCV_WB_FWD_EN
                #1;
                chk($sformatf("b2b_fwd_rsd%0d", i),  {27'd0, wb_fwd_rsd}, i);
                chk($sformatf("b2b_fwd_data%0d", i), wb_fwd_data,         32'h100 + i);
`endif
                @(negedge clk);
            end
        end
        idle_inputs();
        @(negedge clk);
        chk("b2b_end_wen", {31'd0, wb_rf_wen}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
